// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
//   imem_we    : 1-cycle write strobe
//   imem_addr  : word address of the write (holds between writes)
//   imem_wdata : 32-bit word to write
// master = loader side (drives), slave = memory side (receives).
interface uart_imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_imem_loader.sv
// UART (8N1) boot loader for the core's instruction memory.
// Bytes arrive little-endian, are packed into 32-bit words and written to
// sequential word addresses starting at 0. The core is held in reset until
// loading finishes (word limit reached or the line goes idle long enough).
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   rx        : UART serial input, idle high, asynchronous to clk
//   reload    : 1-cycle pulse, restarts loading (only while done)
//   imem      : instruction memory write port (master modport)
//   core_rst  : active-high reset to the core, 1 while loading
//   done      : 1 while loading has finished
//   frame_err : sticky, a stop bit was sampled low since reset/reload
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 6,
    parameter int N_WORDS      = 64,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    input  logic                       reload,
    uart_imem_loader_if.master         imem,
    output logic                       core_rst,
    output logic                       done,
    output logic                       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int WC_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(TIMEOUT_CLKS);
    localparam logic [WC_W-1:0]  WC_END   = WC_W'(N_WORDS);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {LD_LOAD, LD_FLUSH, LD_DONE} ld_state_t;

    // ---------------- rx synchroniser ----------------
    logic rx_s1_q, rx_s2_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t        rx_st_q, rx_st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             byte_valid;
    logic             ferr_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            rx_st_q <= rx_st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        byte_valid = 1'b0;
        ferr_set   = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_st_d = RX_START;
                    cnt_d   = HALF_BIT;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s2_q) begin
                    rx_st_d = RX_IDLE;
                end else begin
                    rx_st_d = RX_DATA;
                    cnt_d   = FULL_BIT;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d = {rx_s2_q, data_q[7:1]};
                    cnt_d  = FULL_BIT;
                    if (bit_q == 3'd7) rx_st_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s2_q) begin
                    byte_valid = 1'b1;
                    rx_st_d    = RX_IDLE;
                end else begin
                    ferr_set = 1'b1;
                    rx_st_d  = RX_WAIT;
                end
            end
            RX_WAIT: begin
                // a broken frame leaves rx low; resync only once the line is idle
                if (rx_s2_q) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // ---------------- loader ----------------
    ld_state_t         ld_q, ld_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       shift_q, shift_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              armed_q, armed_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_q    <= LD_LOAD;
            wcnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            tmr_q   <= '0;
            armed_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            ld_q    <= ld_d;
            wcnt_q  <= wcnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            tmr_q   <= tmr_d;
            armed_q <= armed_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        ld_d    = ld_q;
        wcnt_d  = wcnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        tmr_d   = tmr_q;
        armed_d = armed_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ferr_d  = ferr_q | ferr_set;
        case (ld_q)
            LD_LOAD: begin
                if (wcnt_q == WC_END) begin
                    ld_d = LD_DONE;
                end else if (byte_valid) begin
                    armed_d = 1'b1;
                    tmr_d   = '0;
                    bidx_d  = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[ADDR_W-1:0];
                        wdata_d = {data_q, shift_q[23:0]};
                        wcnt_d  = wcnt_q + 1'b1;
                        // cleared lanes become the zero fill of a later partial flush
                        shift_d = '0;
                    end else begin
                        shift_d[8*bidx_q +: 8] = data_q;
                    end
                end else if (armed_q && tmr_q == TMR_END) begin
                    ld_d = (bidx_q != 2'd0) ? LD_FLUSH : LD_DONE;
                end else if (armed_q && rx_st_q == RX_IDLE) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            LD_FLUSH: begin
                we_d    = 1'b1;
                addr_d  = wcnt_q[ADDR_W-1:0];
                wdata_d = shift_q;
                wcnt_d  = wcnt_q + 1'b1;
                bidx_d  = '0;
                shift_d = '0;
                ld_d    = LD_DONE;
            end
            LD_DONE: begin
                if (reload) begin
                    ld_d    = LD_LOAD;
                    wcnt_d  = '0;
                    bidx_d  = '0;
                    shift_d = '0;
                    ferr_d  = 1'b0;
                    armed_d = 1'b0;
                    tmr_d   = '0;
                end
            end
            default: ld_d = LD_LOAD;
        endcase
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign done            = (ld_q == LD_DONE);
    assign core_rst        = (ld_q != LD_DONE);
    assign frame_err       = ferr_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;
    localparam int CPB     = 16;
    localparam int AW      = 6;
    localparam int NW      = 4;
    localparam int TMO     = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic reload = 1'b0;
    logic core_rst, done, frame_err;

    uart_imem_loader_if #(.ADDR_W(AW)) bus ();

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(AW),
        .N_WORDS(NW),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .reload(reload),
        .imem(bus.master),
        .core_rst(core_rst),
        .done(done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = -10;
    int done_rise_cyc = -10;
    logic prev_we = 1'b0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];

    // reference model: bytes since (re)start, split into complete words
    logic       m_loading;
    int         m_words;
    logic [7:0] m_part[$];
    logic       m_any;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_restart();
        m_loading = 1'b1;
        m_words   = 0;
        m_part.delete();
        m_any     = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (!m_loading) return;
        m_any = 1'b1;
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            w.addr = AW'(m_words);
            w.data = 32'(m_part[0]) + (32'(m_part[1]) << 8) +
                     (32'(m_part[2]) << 16) + (32'(m_part[3]) << 24);
            exp_q.push_back(w);
            m_words++;
            m_part.delete();
            if (m_words == NW) m_loading = 1'b0;
        end
    endtask

    // line went idle long enough: leftover bytes become one zero-padded word
    task automatic model_idle();
        wr_t w;
        if (m_loading && m_any) begin
            if (m_part.size() > 0) begin
                w.addr = AW'(m_words);
                w.data = '0;
                for (int i = 0; i < m_part.size(); i++)
                    w.data = w.data | (32'(m_part[i]) << (8 * i));
                exp_q.push_back(w);
                m_part.delete();
            end
            m_loading = 1'b0;
        end
    endtask

    always @(posedge clk) cyc++;

    // scoreboard monitor
    always @(negedge clk) begin
        wr_t w;
        if (bus.imem_we === 1'b1) begin
            chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(bus.imem_addr), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("write_addr", 32'(bus.imem_addr), 32'(w.addr));
                chk("write_data", bus.imem_wdata, w.data);
            end
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
        prev_we   = bus.imem_we;
        prev_done = done;
    end

    task automatic send_bits(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        if (good_stop) model_byte(b);
        send_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bits(b[i], CPB);
        send_bits(good_stop, CPB);
        if (!good_stop) send_bits(1'b1, CPB);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("done_set", {31'd0, done}, 32'd1);
        chk("core_rst_released", {31'd0, core_rst}, 32'd0);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    // idle after a partial program: must not finish early, must finish by the timeout
    task automatic idle_finish();
        model_idle();
        repeat (TMO - 100) @(negedge clk);
        chk("no_early_done", {31'd0, done}, 32'd0);
        wait_done(300);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        chk("reload_core_rst", {31'd0, core_rst}, 32'd1);
        chk("reload_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reload_done", {31'd0, done}, 32'd0);
        model_restart();
    endtask

    logic [7:0] t3[6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB};
    logic [7:0] t1[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};

    initial begin
        int n;
        model_restart();
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // no bytes yet: stays loading well beyond the timeout
        repeat (TMO + 100) @(negedge clk);
        chk("no_bytes_stays_loading", {31'd0, core_rst}, 32'd1);

        // two full words then idle timeout
        foreach (t1[i]) send_byte(t1[i], 1'b1);
        idle_finish();

        // 16 bytes fill all words, done right after the last write
        do_reload();
        for (int i = 0; i < 4 * NW; i++) send_byte(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        chk("done_after_last_write", 32'(done_rise_cyc - last_we_cyc), 32'd1);
        wait_done(10);
        send_byte(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        chk("extra_byte_still_done", {31'd0, done}, 32'd1);

        // partial word is flushed with zero fill
        do_reload();
        foreach (t3[i]) send_byte(t3[i], 1'b1);
        idle_finish();

        // framing error: byte dropped, later bytes align from lane 0
        do_reload();
        send_byte(8'h55, 1'b0);
        chk("frame_err_set", {31'd0, frame_err}, 32'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle_finish();
        chk("frame_err_sticky", {31'd0, frame_err}, 32'd1);

        // random programs, each preceded by a start-bit glitch
        for (int r = 0; r < 4; r++) begin
            do_reload();
            send_bits(1'b0, 5);
            send_bits(1'b1, 3 * CPB);
            chk("glitch_no_frame_err", {31'd0, frame_err}, 32'd0);
            chk("glitch_core_rst", {31'd0, core_rst}, 32'd1);
            n = $urandom_range(1, 4 * NW + 2);
            for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
            model_idle();
            wait_done(TMO + 200);
        end

        // reset mid-word discards the partial bytes
        do_reload();
        send_byte(8'hE1, 1'b1);
        send_byte(8'hE2, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midword_rst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("midword_rst_addr", 32'(bus.imem_addr), 32'd0);
        rst = 1'b1;
        model_restart();
        @(negedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle_finish();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
